// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter plus req/ack instruction fetch with a valid/ready handoff to decode.
// Defining PC_FETCH_EXCEPTION_EN adds the exc_req/epc exception redirect to EXC_VECTOR.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef PC_FETCH_EXCEPTION_EN
  , parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
`ifdef PC_FETCH_EXCEPTION_EN
  input  logic        exc_req,
  output logic [31:0] epc,
`endif
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);
  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, next_pc;
  logic        accept;
  assign imem_req    = state_q == FETCH;
  assign instr_valid = state_q == VALID;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr       = instr_q;
  assign accept      = instr_valid & instr_ready & ~stall;
  // Masking the offset keeps the low two bits of the shifted immediate out of the target.
  assign next_pc = jump         ? {pc_plus4[31:28], jump_index, 2'b00} :
                   branch_taken ? pc_plus4 + (branch_offset & ~32'd3) : pc_plus4;
`ifdef PC_FETCH_EXCEPTION_EN
  logic [31:0] epc_q, epc_d;
  assign epc = epc_q;
`endif
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef PC_FETCH_EXCEPTION_EN
    epc_d   = epc_q;
`endif
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = VALID;
        end
      end
      VALID: begin
`ifdef PC_FETCH_EXCEPTION_EN
        if (exc_req) begin
          epc_d   = pc_q;
          pc_d    = EXC_VECTOR;
          state_d = FETCH;
        end else
`endif
        if (accept) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
`ifdef PC_FETCH_EXCEPTION_EN
      epc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef PC_FETCH_EXCEPTION_EN
      epc_q   <= epc_d;
`endif
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: vector table of accept-cycle controls with a fetch-address scoreboard
// fed by the expected next PC and drained by a 2-cycle-latency memory responder.
module tb_pc_fetch_unit;
  logic        clk = 0, rst_n = 0, stall = 0, branch_taken = 0, jump = 0, instr_ready = 0;
  logic [31:0] branch_offset = 0;
  logic [25:0] jump_index = 0;
  logic        imem_req, imem_ack, instr_valid;
  logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4;
  logic        resp_ack = 0, force_ack = 0, mem_en = 1;
  logic [31:0] resp_rdata = 0;
`ifdef PC_FETCH_EXCEPTION_EN
  logic        exc_req = 0;
  logic [31:0] epc;
`endif
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  int          n_cmp = 0, n_fail = 0;

  assign imem_ack   = resp_ack | force_ack;
  assign imem_rdata = force_ack ? 32'hBAD0_BAD0 : resp_rdata;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index),
`ifdef PC_FETCH_EXCEPTION_EN
    .exc_req(exc_req), .epc(epc),
`endif
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .pc(pc), .pc_plus4(pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_valid();
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        ok = 1;
        break;
      end
    end
    check("wait_valid", {31'd0, ok}, 32'd1);
  endtask

  task automatic check_valid(input logic [31:0] p);
    check("pc", pc, p);
    check("pc_plus4", pc_plus4, p + 32'd4);
    check("instr", instr, memf(p));
  endtask

  // Memory model: ack two cycles after the request is seen, checking the scoreboard address.
  initial begin
    logic [31:0] a;
    forever begin
      @(posedge clk); #1;
      if (mem_en && imem_req) begin
        a = imem_addr;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL imem_addr: unexpected fetch of %h, want none", a);
        end else check("imem_addr", a, exp_q.pop_front());
        @(posedge clk); #1;
        check("addr_stable", imem_addr, a);
        check("req_held", {31'd0, imem_req}, 32'd1);
        resp_ack = 1;
        resp_rdata = memf(a);
        @(posedge clk); #1;
        resp_ack = 0;
        resp_rdata = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        br;
    logic        jmp;
    logic [31:0] off;
    logic [25:0] idx;
    int          stall_n;
    logic [31:0] nxt;
  } vec_t;
  vec_t v[11];

  initial begin
    v[0]  = '{1'b0, 1'b0, 32'h0,         26'h0,       0, 32'h4};
    v[1]  = '{1'b0, 1'b0, 32'h0,         26'h0,       3, 32'h8};
    v[2]  = '{1'b0, 1'b1, 32'h0,         26'h40,      0, 32'h100};
    v[3]  = '{1'b1, 1'b0, 32'hFFFF_FFF0, 26'h0,       0, 32'hF4};
    v[4]  = '{1'b0, 1'b1, 32'h0,         26'h40,      0, 32'h100};
    v[5]  = '{1'b1, 1'b0, 32'h0000_0013, 26'h0,       0, 32'h114};
    v[6]  = '{1'b0, 1'b1, 32'h0,         26'h10_0004, 0, 32'h0040_0010};
    v[7]  = '{1'b1, 1'b1, 32'h20,        26'h40,      0, 32'h100};
    v[8]  = '{1'b1, 1'b0, 32'hFFFF_FEF8, 26'h0,       0, 32'hFFFF_FFFC};
    v[9]  = '{1'b0, 1'b0, 32'h0,         26'h0,       1, 32'h0};
    v[10] = '{1'b0, 1'b0, 32'h0,         26'h0,       0, 32'h4};

    #12;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_pc_plus4", pc_plus4, 32'd4);
    exp_q.push_back(32'h0);
    exp_pc = 32'h0;
    @(negedge clk);
    rst_n = 1;
    #1 check("idle_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    check("idle_one_cycle", {31'd0, imem_req}, 32'd1);

    for (int k = 0; k < 11; k++) begin
      wait_valid();
      check_valid(exp_pc);
      if (v[k].stall_n > 0) begin
        @(negedge clk);
        stall = 1;
        instr_ready = 1;
        for (int s = 0; s < v[k].stall_n; s++) begin
          @(posedge clk); #1;
          check("stall_valid", {31'd0, instr_valid}, 32'd1);
          check("stall_no_req", {31'd0, imem_req}, 32'd0);
          check("stall_pc", pc, exp_pc);
          check("stall_instr", instr, memf(exp_pc));
        end
      end
      @(negedge clk);
      stall = 0;
      instr_ready = 1;
      branch_taken = v[k].br;
      jump = v[k].jmp;
      branch_offset = v[k].off;
      jump_index = v[k].idx;
      exp_q.push_back(v[k].nxt);
      @(posedge clk); #1;
      check("accept_valid", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
      instr_ready = 0;
      branch_taken = 1;
      jump = 1;
      branch_offset = $urandom;
      jump_index = 26'($urandom);
      exp_pc = v[k].nxt;
    end

    wait_valid();
    check_valid(exp_pc);
`ifdef PC_FETCH_EXCEPTION_EN
    @(negedge clk);
    exc_req = 1;
    exp_q.push_back(32'h8000_0180);
    @(posedge clk); #1;
    check("epc", epc, exp_pc);
    check("exc_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    exc_req = 0;
    exp_pc = 32'h8000_0180;
    wait_valid();
    check_valid(exp_pc);
`endif

    @(negedge clk);
    mem_en = 0;
    branch_taken = 0;
    jump = 0;
    instr_ready = 1;
    @(posedge clk); #1;
    instr_ready = 0;
    check("pre_rst_req", {31'd0, imem_req}, 32'd1);
    @(negedge clk);
    rst_n = 0;
    #1;
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_pc", pc, 32'd0);
    check("midrst_instr", instr, 32'd0);
    exp_q.push_back(32'h0);
    exp_pc = 32'h0;
    @(negedge clk);
    rst_n = 1;
    force_ack = 1;
    mem_en = 1;
    @(posedge clk); #1;
    force_ack = 0;
    check("late_ack_req", {31'd0, imem_req}, 32'd1);
    check("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    wait_valid();
    check_valid(exp_pc);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
